// File: rtl/prog_load_ctrl.sv
// Program-load front end: debounced buttons, two-byte instruction entry into
// instruction memory, then single-step / free-run gating of the datapath clock.

module prog_load_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, require a run of differing samples before flipping, pulse on rising flips.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign press = press_r;
endmodule

module prog_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_W          = 8,
    parameter int RUN_DIV         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        input_instruction,
    input  logic              button,
    input  logic              pc_butt,
    input  logic              run_sw,
    input  logic              halt_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              clk_enable,
    output logic              cpu_hold,
    output logic [15:0]       led_ins,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {
        LOAD_HI = 3'd0,
        LOAD_LO = 3'd1,
        WRITE   = 3'd2,
        READY   = 3'd3,
        RUN     = 3'd4,
        STEP    = 3'd5,
        HALTED  = 3'd6
    } state_t;

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [15:0]       HALT_WORD = 16'hFFFF;

    // word_cnt needs one extra bit so a completely full memory still reads back correctly.
    function automatic logic [15:0] cnt_led(input logic [CNT_W-1:0] cnt);
        return 16'(cnt);
    endfunction

    state_t            state_r;
    logic [7:0]        hi_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;
    logic [CNT_W-1:0]  wcnt_r;
    logic [DIV_W-1:0]  div_r;
    logic              we_r;
    logic              clk_en_r;
    logic              hold_r;
    logic [15:0]       led_r;
    logic [DIV_W-1:0]  div_next_s;
    logic              btn_press_s;
    logic              pc_press_s;

    prog_load_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk   (clk),
        .reset (reset),
        .raw   (button),
        .press (btn_press_s)
    );

    prog_load_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pc_db (
        .clk   (clk),
        .reset (reset),
        .raw   (pc_butt),
        .press (pc_press_s)
    );

    // Free-run divider wraps at RUN_DIV-1.
    always_comb begin
        div_next_s = {DIV_W{1'b0}};
        if (div_r == DIV_LAST) begin
            div_next_s = {DIV_W{1'b0}};
        end else begin
            div_next_s = div_r + DIV_W'(1'b1);
        end
    end

    // Sequencer: load states, write strobe, then step/run gating until halt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= LOAD_HI;
            hi_r     <= 8'h00;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 16'h0000;
            wcnt_r   <= {CNT_W{1'b0}};
            div_r    <= {DIV_W{1'b0}};
            we_r     <= 1'b0;
            clk_en_r <= 1'b0;
            hold_r   <= 1'b1;
            led_r    <= 16'h0000;
        end else begin
            we_r     <= 1'b0;
            clk_en_r <= 1'b0;
            case (state_r)
                LOAD_HI: begin
                    if (btn_press_s) begin
                        hi_r    <= input_instruction;
                        state_r <= LOAD_LO;
                        led_r   <= {input_instruction, input_instruction};
                    end else begin
                        led_r <= {hi_r, input_instruction};
                    end
                end
                LOAD_LO: begin
                    led_r <= {hi_r, input_instruction};
                    if (btn_press_s) begin
                        wdata_r <= {hi_r, input_instruction};
                        we_r    <= 1'b1;
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    wcnt_r <= wcnt_r + CNT_W'(1'b1);
                    if (wdata_r == HALT_WORD || addr_r == ADDR_LAST) begin
                        state_r <= READY;
                        addr_r  <= {ADDR_W{1'b0}};
                        hold_r  <= 1'b0;
                        led_r   <= cnt_led(wcnt_r + CNT_W'(1'b1));
                    end else begin
                        state_r <= LOAD_HI;
                        addr_r  <= addr_r + ADDR_W'(1'b1);
                        led_r   <= {hi_r, input_instruction};
                    end
                end
                READY, HALTED: begin
                    if (btn_press_s) begin
                        state_r <= LOAD_HI;
                        addr_r  <= {ADDR_W{1'b0}};
                        wcnt_r  <= {CNT_W{1'b0}};
                        hi_r    <= 8'h00;
                        hold_r  <= 1'b1;
                        led_r   <= {8'h00, input_instruction};
                    end else if (state_r == READY && run_sw) begin
                        state_r <= RUN;
                        div_r   <= {DIV_W{1'b0}};
                    end else if (state_r == READY && pc_press_s) begin
                        state_r  <= STEP;
                        clk_en_r <= 1'b1;
                    end
                end
                STEP: begin
                    state_r <= halt_in ? HALTED : READY;
                end
                RUN: begin
                    if (halt_in) begin
                        state_r <= HALTED;
                    end else if (!run_sw) begin
                        state_r <= READY;
                    end else begin
                        div_r    <= div_next_s;
                        clk_en_r <= (div_next_s == DIV_LAST);
                    end
                end
                default: begin
                    state_r <= LOAD_HI;
                    addr_r  <= {ADDR_W{1'b0}};
                    hold_r  <= 1'b1;
                end
            endcase
        end
    end

    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    // A halt seen in the pulse cycle itself cancels that pulse.
    assign clk_enable = clk_en_r && !(state_r == RUN && halt_in);
    assign cpu_hold   = hold_r;
    assign led_ins    = led_r;
    assign state_o    = state_r;
endmodule
